// File: rtl/ml_if_fifo_buf.sv
// ml_if_fifo_buf: input-feature staging FIFO between the IF SRAM and the PE
// array. Responds to push/pop commands from the control FSM, reports
// full/empty, and tags every popped word with a wrapping PE row index.
module ml_if_fifo_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 15,
  parameter int Y_DIM  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 fifo_ctrl,
  output logic [1:0]                 fifo_resp,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(Y_DIM)-1:0]   rd_row_idx,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err,
  output logic                       udf_err,
  input  logic                       clr_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = $clog2(Y_DIM);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Y_DIM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ROW_W-1:0]  r_row_cnt;
  logic [ROW_W-1:0]  r_row_idx;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop_req;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status and command qualification, all from registered occupancy.
  always_comb begin
    w_full     = (r_count == CNT_FULL);
    w_empty    = (r_count == '0);
    w_push_req = fifo_ctrl[0];
    w_pop_req  = fifo_ctrl[1];
    // A pop is only possible with data present; at empty a concurrent push
    // does not read through.
    w_pop_acc  = w_pop_req && !w_empty;
    // At full, a push is still taken when a pop frees a slot this cycle.
    w_push_acc = w_push_req && (!w_full || w_pop_acc);
    w_ovf_evt  = w_push_req && w_full && !w_pop_acc;
    w_udf_evt  = w_pop_req && w_empty;
  end

  // Storage array; written on accepted pushes, contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_acc && !w_push_acc) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Registered read port plus row tagging; row counter survives emptying.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_row_idx  <= '0;
      r_row_cnt  <= '0;
    end else begin
      r_rd_valid <= w_pop_acc;
      if (w_pop_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_row_idx <= r_row_cnt;
        r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt || (r_ovf && !clr_err);
      r_udf <= w_udf_evt || (r_udf && !clr_err);
    end
  end

  assign fifo_resp  = {w_empty, w_full};
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign rd_row_idx = r_row_idx;
  assign count      = r_count;
  assign ovf_err    = r_ovf;
  assign udf_err    = r_udf;

endmodule

// File: doc/ml_if_fifo_buf.md
Name: ml_if_fifo_buf

Overview:
- Input-feature staging buffer between the IF SRAM and the PE array input register files.
- Acts as the responder on the 2-bit FIFO control/response interface driven by the ML control FSM.
  - Accepts push commands (SRAM to buffer) and pop commands (buffer to PE).
  - Returns full/empty status that the FSM uses to sequence its load phases.
- Also tags each popped word with a PE row index, so the PE-side demux can select the destination row register file.

Parameters:
- DATA_W, 16, width of one input-feature word.
- DEPTH, 15, number of FIFO entries; need not be a power of two.
- Y_DIM, 15, number of PE rows; sets the wrap point of the row index.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- fifo_ctrl  input  2  [0]=push (write wr_data), [1]=pop (read toward PE).
- fifo_resp  output  2  [0]=full, [1]=empty.
- wr_data  input  DATA_W  word written on an accepted push.
- rd_data  output  DATA_W  word delivered on an accepted pop; registered.
- rd_valid  output  1  one-cycle pulse, qualifies rd_data and rd_row_idx.
- rd_row_idx  output  $clog2(Y_DIM)  PE row index associated with rd_data.
- count  output  $clog2(DEPTH+1)  current occupancy.
- ovf_err  output  1  sticky: push attempted while full and not popping.
- udf_err  output  1  sticky: pop attempted while empty.
- clr_err  input  1  clears ovf_err and udf_err on next edge.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of other inputs:
  - count=0, write/read pointers=0, rd_row_idx=0, rd_valid=0, rd_data=0, ovf_err=0, udf_err=0.
  - fifo_resp=2'b10 (empty=1, full=0).
  - Reset mid-operation discards all contents; the pop in that cycle is not delivered.
- Status:
  - full = (count==DEPTH); empty = (count==0).
  - Both are derived combinationally from the registered count, so they reflect the operation one cycle after it is accepted.
- Pointers: write and read pointers range 0..DEPTH-1 and wrap explicitly DEPTH-1 -> 0. Modulo-2^n wrapping is not permitted.
- Push accepted when fifo_ctrl[0]=1 and (not full, or pop also accepted this cycle).
  - wr_data stored at the write pointer; write pointer advances.
- Pop accepted when fifo_ctrl[1]=1 and not empty. Next edge:
  - rd_data = entry at the read pointer.
  - rd_valid=1; rd_row_idx = row counter value.
  - Read pointer advances.
  - Row counter advances, wrapping Y_DIM-1 -> 0.
- Read latency: one cycle from the pop edge to rd_valid/rd_data. rd_valid is low in every cycle without an accepted pop; rd_data holds its last value.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged when both are accepted or neither is.
- Simultaneous push+pop:
  - At full: both accepted, count stays DEPTH; popped word is the oldest entry.
  - At empty: push accepted, pop rejected, udf_err set, count becomes 1. No read-through: the new word is not delivered in the same cycle.
- Overflow: push while full with no pop. Word dropped, ovf_err set, state otherwise unchanged.
- Underflow: pop while empty. No rd_valid, pointers unchanged, udf_err set.
- Error flags:
  - Sticky until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
- Row counter: not cleared when the FIFO empties; only rst resets it. It counts accepted pops modulo Y_DIM.
- fifo_ctrl=2'b00 is idle; no state change.

Test Plan:
- Reset check: rst for 2 cycles, then release -> fifo_resp=2'b10, count=0, rd_valid=0, both error flags 0.
- Fill and overflow:
  - Push 0x0001..0x000F on consecutive cycles -> one cycle after the 15th push, fifo_resp=2'b01 and count=15.
  - 16th push of 0x00FF -> ovf_err=1, count stays 15, 0x00FF is never read back.
- Drain and order:
  - Pop 15 times -> rd_data = 0x0001..0x000F in order, rd_valid high each cycle after a pop, rd_row_idx = 0..14.
  - Then fifo_resp=2'b10.
  - A 16th pop -> udf_err=1, no rd_valid.
- Full simultaneous and pointer wrap:
  - From full (0x0001..0x000F), assert push 0x0100 together with pop -> popped 0x0001, count stays 15.
  - Drain the remaining 15 entries -> 0x0002..0x000F then 0x0100 (write pointer wrapped to entry 0).
- Row wrap: 20 push/pop pairs -> rd_row_idx sequence 0..14, then 0..4.
- Errors and reset:
  - Pulse clr_err alone -> both flags clear.
  - Load 5 words, assert rst for one cycle together with a pop -> no rd_valid, count=0, empty=1.
  - The next push/pop returns the newly pushed word.
